// File: rtl/multi_flexible_clock.sv
// Multi-channel clock divider: per-channel square wave plus edge tick strobe,
// each with its own divisor (latched only at half-period boundaries) and enable.
module multi_flexible_clock #(
   parameter int unsigned CHANNELS = 4,
   parameter int unsigned WIDTH    = 32
) (
   input  logic                      basys_clock,
   input  logic                      rst_n,
   input  logic [CHANNELS-1:0]       en,
   input  logic                      sync,
   input  logic [CHANNELS*WIDTH-1:0] m,
   output logic [CHANNELS-1:0]       slow_clock,
   output logic [CHANNELS-1:0]       tick
);

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic [WIDTH-1:0] cnt_q, cnt_d;
      logic [WIDTH-1:0] m_act_q, m_act_d;
      logic             slow_q, slow_d;
      logic             tick_q, tick_d;

      // Next state: sync restarts, disabled holds, wrap toggles and reloads divisor.
      always_comb begin
         cnt_d   = cnt_q;
         m_act_d = m_act_q;
         slow_d  = slow_q;
         tick_d  = 1'b0;
         if (sync) begin
            cnt_d   = '0;
            m_act_d = '0;
            slow_d  = 1'b0;
         end else if (en[i]) begin
            if (cnt_q == m_act_q) begin
               cnt_d   = '0;
               slow_d  = ~slow_q;
               tick_d  = 1'b1;
               m_act_d = m[i*WIDTH +: WIDTH];
            end else begin
               cnt_d = cnt_q + WIDTH'(1);
            end
         end
      end

      always_ff @(posedge basys_clock or negedge rst_n) begin
         if (!rst_n) begin
            cnt_q   <= '0;
            m_act_q <= '0;
            slow_q  <= 1'b0;
            tick_q  <= 1'b0;
         end else begin
            cnt_q   <= cnt_d;
            m_act_q <= m_act_d;
            slow_q  <= slow_d;
            tick_q  <= tick_d;
         end
      end

      assign slow_clock[i] = slow_q;
      assign tick[i]       = tick_q;
   end

endmodule

// File: doc/multi_flexible_clock.md
# multi_flexible_clock

Parametrised multi-channel clock divider: generates `CHANNELS` independent divided square waves plus matching one-cycle tick strobes from the 100 MHz board clock. Each channel has its own run-time divisor, enable and glitch-free divisor update at period boundaries. A shared `sync` input phase-aligns all channels. It replaces the single-channel divider and feeds display refresh, debouncers and animation timers.

## Interface

Parameters:
- `CHANNELS`, 4, number of independent divider channels (≥1)
- `WIDTH`, 32, width of each divisor and counter (≥1)

Ports:
- `basys_clock` in 1: system clock, all logic on its rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `en` in CHANNELS: per-channel run enable, bit i controls channel i
- `sync` in 1: synchronous restart of all channels
- `m` in CHANNELS*WIDTH: packed divisors, channel i uses `m[i*WIDTH +: WIDTH]`, unsigned
- `slow_clock` out CHANNELS: divided square waves, registered
- `tick` out CHANNELS: one-cycle strobe on each `slow_clock` edge, registered

## Operation

Per-channel state: counter `cnt` (WIDTH bits), active divisor `m_act` (WIDTH bits), `slow_clock[i]`, `tick[i]`.
- Reset (`rst_n`=0, asynchronous): `cnt`=0, `m_act`=0, `slow_clock`=0, `tick`=0 for every channel.
- Each rising edge, per channel, in priority order:
  - `sync`=1: `cnt`←0, `m_act`←0, `slow_clock`←0, `tick`←0. Same as reset; `en` is ignored.
  - `en[i]`=0: `cnt`, `m_act` and `slow_clock` hold; `tick`←0.
  - `en[i]`=1 and `cnt`==`m_act` (wrap): `cnt`←0, `slow_clock`←~`slow_clock`, `tick`←1, `m_act`←`m_i` (current input divisor).
  - `en[i]`=1 otherwise: `cnt`←`cnt`+1, `tick`←0.
- Half-period = `m_act`+1 cycles. Full period = 2(`m_act`+1). Output frequency = f_clk / (2(m+1)).
- `m`=0: `slow_clock` toggles every enabled cycle (f_clk/2) and `tick` stays high continuously.
- Divisor changes take effect only at a wrap. A half-period in progress always completes with the old divisor, so there are no runt pulses.
- Because `m_act` resets to 0, the first enabled cycle after reset or `sync` is a wrap. `slow_clock` goes 1, `tick` pulses, and `m` is loaded.
- Counter never exceeds `m_act`, so there is no overflow. `m`=2^WIDTH−1 is legal.
- Channels are fully independent apart from the shared `sync` and reset.

## Timing

- All outputs change only on the `basys_clock` rising edge, except the asynchronous reset to 0.
- Reset release: outputs stay 0 until the first rising edge with `rst_n`=1, `sync`=0 and `en[i]`=1. That edge makes `slow_clock[i]`=1 and `tick[i]`=1.
- `tick[i]` is high for exactly one cycle, coincident with the cycle in which `slow_clock[i]` holds its new value (except `m`=0, see above).
- `en` deassertion takes effect on the next edge: no wrap occurs and `tick` drops. On reassertion, counting resumes from the held `cnt`.
- `sync` asserted for several cycles holds all channels in the reset state. The wrap occurs on the first enabled edge after `sync` falls.
- Reset mid-period: all state clears immediately. The partial period is discarded.

## Test plan

- Reset, then `en`=1, `m0`=3: `slow_clock[0]` edges at cycles 1,5,9,13 (high 4, low 4), and `tick[0]` is high on exactly those cycles.
- `m0`=0: `slow_clock[0]` toggles every cycle and `tick[0]` stays 1. Switch to `m0`=2 mid-half-period: the current half-period finishes at the old length, then half-periods are 3 cycles.
- Channels 0..3 with `m`=1,2,3,9 running simultaneously: half-periods are 2,3,4,10 cycles, with no cross-channel interference.
- `m0`=4, drop `en[0]` for 7 cycles mid-count: `slow_clock[0]` holds, `tick[0]`=0. After re-enable the remaining count completes, so the total half-period is 5 enabled cycles.
- Channels running with different phases, pulse `sync` for 1 cycle: all `slow_clock` go 0, then all go 1 together on the next edge and remain phase-aligned if their `m` values are equal.
- Assert `rst_n`=0 asynchronously between edges mid-period: all outputs go 0 immediately. After release, behaviour matches the first scenario.
